// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC register, tagged prefetch FIFO and decode handshake
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd2,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_next
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [15:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [15:0]   instr_mem_q [FIFO_DEPTH];
    logic [15:0]   pc_mem_q    [FIFO_DEPTH];
    logic          pop, push;

    assign id_valid   = count_q != '0;
    assign pop        = id_valid & id_ready;
    assign push       = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);
    assign imem_pc    = pc_q;
    assign id_instr   = id_valid ? instr_mem_q[rd_q] : '0;
    assign id_pc      = id_valid ? pc_mem_q[rd_q] : '0;
    assign id_pc_next = id_valid ? pc_mem_q[rd_q] + PC_STEP : '0;

    // Next state: a redirect flushes the FIFO and reloads the PC; otherwise push/pop bookkeeping
    always_comb begin
        pc_d    = redirect_valid ? {redirect_pc[15:1], 1'b0} : (push ? pc_q + PC_STEP : pc_q);
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        rd_d    = redirect_valid ? '0 : rd_q + AW'(pop);
        wr_d    = redirect_valid ? '0 : wr_q + AW'(push);
    end

    // Control state, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // FIFO storage; contents are masked by id_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_q] <= imem_instr;
            pc_mem_q[wr_q]    <= pc_q;
        end
    end
endmodule
